seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
Runtime-programmable serial pattern detector. It is the parametrised successor of the fixed 4-bit Moore "1011" detector. Pattern bits and length (1..MAX_LEN) load through a config strobe, overlapping or non-overlapping matching is selectable, input is qualified by a valid, and a saturating match counter is provided. It sits in the serial-stream monitoring path; detect_out drives downstream event logic with the same 2-cycle latency as the legacy block.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, $clog2(MAX_LEN+1), width of pat_len
CNT_W, 8, width of match_count
DEF_PATTERN, 8'b0000_1011, pattern after reset (MAX_LEN bits, right-aligned)
DEF_LEN, 4, pattern length after reset
DEF_OVERLAP, 1, overlap mode after reset

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
seq_in  input  1  serial data bit
in_valid  input  1  seq_in sampled only when high
cfg_load  input  1  one-cycle strobe; latches pattern/pat_len/overlap_en
pattern  input  MAX_LEN  pattern; bit [pat_len-1] is received first, bit [0] last
pat_len  input  LEN_W  pattern length, legal 1..MAX_LEN
overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping
detect_out  output  1  registered one-cycle match pulse
match_count  output  CNT_W  saturating count of matches
cfg_err  output  1  high while the active config has an illegal length

Behaviour:
- Reset (async) values:
  - hist = 0, fill = 0, shifted_q = 0
  - detect_out = 0, match_count = 0, cfg_err = 0
  - active config = DEF_PATTERN / DEF_LEN / DEF_OVERLAP
- Internal state:
  - hist: MAX_LEN-bit shift register.
  - fill: count of valid bits since last reset/load/non-overlap match, saturating at MAX_LEN.
  - shifted_q: in_valid registered.
- Edge with in_valid=1 and cfg_load=0: hist <= {hist[MAX_LEN-2:0], seq_in}; fill <= min(fill+1, MAX_LEN); shifted_q <= 1.
- Edge with in_valid=0: hist and fill hold; shifted_q <= 0.
- match (combinational): shifted_q & !cfg_err & (fill >= len) & (hist[len-1:0] == pat[len-1:0]). Bits above len are ignored.
- Every edge: detect_out <= match. Latency: last pattern bit sampled at edge k gives detect_out high for exactly the one cycle after edge k+1.
- A held pattern never re-fires without new valid bits, because shifted_q gates match.
- When match=1 at an edge:
  - match_count increments unless already all-ones (saturates, never wraps).
  - If overlap=0, fill <= 0 on that same edge (overrides the shift update if in_valid=1, then fill <= 1 if that bit was valid). Bits shifted after the match start a fresh window.
  - If overlap=1, fill is unaffected and a suffix may complete a new match.
- cfg_load edge (dominates in_valid):
  - Latch the new config.
  - fill <= 0, shifted_q <= 0, detect_out <= 0, match_count <= 0.
  - seq_in on that edge is discarded.
  - cfg_err <= (pat_len == 0 || pat_len > MAX_LEN).
- While cfg_err=1, match is forced 0 and shifting continues. Only a legal cfg_load clears cfg_err.
- Reset mid-stream: everything returns to reset values immediately, including a pending detect_out pulse.
- pat_len = 1 with overlap: every valid bit equal to pat[0] produces a pulse, so back-to-back valid bits give back-to-back pulses.
- Required assertions:
  - Single-cycle pulse semantics: detect_out |=> !detect_out, unless match was true again.
  - match_count never decrements except on reset or cfg_load.
  - fill <= MAX_LEN.
  - The legacy property "1,0,1,1 on consecutive valid cycles |=> ##1 detect_out" holds under the default config.

Test Plan:
- Reset defaults; stream 1,0,1,1,0,1,1 with in_valid=1 -> detect_out pulses after bits 4 and 7 (each 2 edges after the bit); match_count=2.
- cfg_load pattern=1011, len=4, overlap_en=0; same stream -> one pulse after bit 4 only; match_count=1.
- Default config; stream 1,0 then in_valid=0 for 3 cycles, then 1,1 -> exactly one pulse, 2 edges after the final bit; no pulse during the gap.
- cfg_load pattern=8'b1111_0000, len=8, overlap=1; stream 1111000011110000 -> pulses after bit 8 and bit 16; match_count=2.
- cfg_load len=0 -> cfg_err=1 and no pulses on the default stream; then cfg_load len=9 (MAX_LEN=8) -> cfg_err=1; then legal load -> cfg_err=0 and detection resumes.
- CNT_W=2, pattern=1, len=1, overlap=1, five valid 1s -> five pulses; match_count 1,2,3,3,3. Assert reset during the 5th pulse -> detect_out and match_count go to 0 immediately.

Source files
------------

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector: loadable pattern/length,
// overlap select, valid-qualified input and a saturating match counter.
module seq_detector_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seq_in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap_en,
  output logic               detect_out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] hist_reg, hist_next;
  logic [LEN_W-1:0]   fill_reg, fill_next;
  logic               shifted_reg, shifted_next;
  logic [MAX_LEN-1:0] pat_reg, pat_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic               overlap_reg, overlap_next;
  logic               detect_next;
  logic [CNT_W-1:0]   count_next;
  logic               err_next;

  logic [MAX_LEN-1:0] len_mask;
  logic               len_illegal;
  logic               bits_equal;
  logic               match;

  // Only the low len_reg bits of history/pattern take part in the compare.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign len_mask[gi] = (len_reg > LEN_W'(gi));
  end

  assign len_illegal = (pat_len == '0) || (pat_len > LEN_W'(MAX_LEN));
  assign bits_equal  = (((hist_reg ^ pat_reg) & len_mask) == '0);
  assign match       = shifted_reg && !cfg_err && (fill_reg >= len_reg) && bits_equal;

  always_comb begin
    hist_next    = hist_reg;
    fill_next    = fill_reg;
    shifted_next = 1'b0;
    pat_next     = pat_reg;
    len_next     = len_reg;
    overlap_next = overlap_reg;
    err_next     = cfg_err;
    detect_next  = match;
    count_next   = match_count;

    if (cfg_load) begin
      pat_next     = pattern;
      len_next     = pat_len;
      overlap_next = overlap_en;
      err_next     = len_illegal;
      fill_next    = '0;
      detect_next  = 1'b0;
      count_next   = '0;
    end else begin
      // Non-overlap: the window restarts, but a bit valid on this edge still counts.
      if (match && !overlap_reg) begin
        fill_next = '0;
      end
      if (in_valid) begin
        hist_next    = {hist_reg[MAX_LEN-2:0], seq_in};
        shifted_next = 1'b1;
        if (fill_next != LEN_W'(MAX_LEN)) begin
          fill_next = fill_next + LEN_W'(1);
        end
      end
      if (match && (match_count != '1)) begin
        count_next = match_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_reg    <= '0;
      fill_reg    <= '0;
      shifted_reg <= 1'b0;
      pat_reg     <= DEF_PATTERN;
      len_reg     <= LEN_W'(DEF_LEN);
      overlap_reg <= DEF_OVERLAP;
      cfg_err     <= 1'b0;
      detect_out  <= 1'b0;
      match_count <= '0;
    end else begin
      hist_reg    <= hist_next;
      fill_reg    <= fill_next;
      shifted_reg <= shifted_next;
      pat_reg     <= pat_next;
      len_reg     <= len_next;
      overlap_reg <= overlap_next;
      cfg_err     <= err_next;
      detect_out  <= detect_next;
      match_count <= count_next;
    end
  end

  logic legacy_cfg;
  assign legacy_cfg = (len_reg == LEN_W'(4)) && (pat_reg[3:0] == 4'b1011) && overlap_reg && !cfg_err;

  a_pulse_single : assert property (@(posedge clk) disable iff (reset)
    (detect_out && !match) |=> !detect_out);

  a_count_monotonic : assert property (@(posedge clk) disable iff (reset)
    !cfg_load |=> (match_count >= $past(match_count)));

  a_fill_bound : assert property (@(posedge clk) disable iff (reset)
    fill_reg <= LEN_W'(MAX_LEN));

  // Four consecutive valid bits 1,0,1,1 under the legacy config show up two edges later.
  a_legacy_1011 : assert property (@(posedge clk) disable iff (reset)
    (legacy_cfg
     && $past(in_valid, 5) &&  $past(seq_in, 5)
     && $past(in_valid, 4) && !$past(seq_in, 4)
     && $past(in_valid, 3) &&  $past(seq_in, 3)
     && $past(in_valid, 2) &&  $past(seq_in, 2)
     && !$past(cfg_load, 1) && !$past(cfg_load, 2) && !$past(cfg_load, 3)
     && !$past(cfg_load, 4) && !$past(cfg_load, 5)
     && !$past(reset, 1) && !$past(reset, 2) && !$past(reset, 3)
     && !$past(reset, 4) && !$past(reset, 5))
    |-> detect_out);

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: a behavioural model pushes expected
// detect pulses into a queue, popped and compared after each clock edge.
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       seq_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [3:0] pat_len = 4'd0;
  logic       overlap_en = 1'b0;

  logic       detect_out, detect_c2;
  logic [7:0] match_count;
  logic [1:0] count_c2;
  logic       cfg_err, cfg_err_c2;

  always #5 clk = ~clk;

  seq_detector_prog dut (
    .clk(clk), .reset(reset), .seq_in(seq_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap_en(overlap_en), .detect_out(detect_out),
    .match_count(match_count), .cfg_err(cfg_err)
  );

  seq_detector_prog #(.CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .seq_in(seq_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap_en(overlap_en), .detect_out(detect_c2),
    .match_count(count_c2), .cfg_err(cfg_err_c2)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit         exp_q[$];
  logic [7:0] m_hist, m_pat;
  int         m_fill, m_len, m_cnt8, m_cnt2;
  bit         m_ovl, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_bits_equal();
    for (int i = 0; i < m_len && i < 8; i++)
      if (m_hist[i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(1'b0);
    m_hist = 8'h00; m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b1;
    m_fill = 0; m_err = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  // Advance the model by one edge with the inputs about to be sampled.
  task automatic model_edge(input bit v, input bit b, input bit ld,
                            input logic [7:0] p, input int l, input bit o);
    bit pend, m;
    pend = exp_q[0];
    if (ld) begin
      exp_q[0] = 1'b0;
      m_pat = p; m_len = l; m_ovl = o; m_err = (l == 0) || (l > 8);
      m_fill = 0; m_cnt8 = 0; m_cnt2 = 0;
      exp_q.push_back(1'b0);
    end else begin
      if (pend) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
        if (!m_ovl) m_fill = 0;
      end
      if (v) begin
        m_hist = {m_hist[6:0], b};
        if (m_fill < 8) m_fill++;
      end
      m = v && !m_err && (m_fill >= m_len) && m_bits_equal();
      exp_q.push_back(m);
    end
  endtask

  task automatic check_outputs(input string tag);
    bit exp_det;
    exp_det = exp_q.pop_front();
    $display("[TB] %s t=%0t v=%0b b=%0b ld=%0b det=%0b cnt=%0d cnt2=%0d err=%0b",
             tag, $time, in_valid, seq_in, cfg_load, detect_out, match_count, count_c2, cfg_err);
    check({tag, ".detect"},  {31'd0, detect_out}, {31'd0, exp_det});
    check({tag, ".detect2"}, {31'd0, detect_c2},  {31'd0, exp_det});
    check({tag, ".count"},   {24'd0, match_count}, m_cnt8);
    check({tag, ".count2"},  {30'd0, count_c2},    m_cnt2);
    check({tag, ".cfg_err"}, {31'd0, cfg_err},     {31'd0, m_err});
  endtask

  task automatic step(input string tag, input bit v, input bit b);
    in_valid = v; seq_in = b; cfg_load = 1'b0;
    model_edge(v, b, 1'b0, 8'h00, 0, 1'b0);
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic stream(input string tag, input logic [15:0] bits, input int n);
    logic [15:0] bv;
    bv = bits;
    for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, bv[i]);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0);
  endtask

  // In-flight valid bit on the load edge must be discarded.
  task automatic load(input string tag, input logic [7:0] p, input int l, input bit o);
    cfg_load = 1'b1; pattern = p; pat_len = l[3:0]; overlap_en = o;
    in_valid = 1'b1; seq_in = 1'b1;
    model_edge(1'b1, 1'b1, 1'b1, p, l, o);
    @(posedge clk); #1;
    check_outputs(tag);
    cfg_load = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; in_valid = 1'b0; cfg_load = 1'b0; seq_in = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check({tag, ".rst_detect"}, {31'd0, detect_out}, 0);
    check({tag, ".rst_count"},  {24'd0, match_count}, 0);
    check({tag, ".rst_cfg_err"}, {31'd0, cfg_err}, 0);
  endtask

  initial begin
    // 1: default overlapping 1011 on 1011011 -> two pulses
    do_reset("t1");
    stream("t1", 16'b1011011, 7);
    idle("t1", 2);
    check("t1.total", {24'd0, match_count}, 2);

    // 2: non-overlapping -> only first match
    load("t2", 8'b0000_1011, 4, 1'b0);
    stream("t2", 16'b1011011, 7);
    idle("t2", 2);
    check("t2.total", {24'd0, match_count}, 1);

    // 3: default config with an in_valid gap inside the pattern
    do_reset("t3");
    step("t3", 1'b1, 1'b1);
    step("t3", 1'b1, 1'b0);
    idle("t3", 3);
    step("t3", 1'b1, 1'b1);
    step("t3", 1'b1, 1'b1);
    idle("t3", 3);
    check("t3.total", {24'd0, match_count}, 1);

    // 4: full-length 8-bit pattern, overlapping
    load("t4", 8'b1111_0000, 8, 1'b1);
    stream("t4", 16'b1111000011110000, 16);
    idle("t4", 2);
    check("t4.total", {24'd0, match_count}, 2);

    // 5: illegal lengths block detection; a legal load resumes it
    load("t5a", 8'b0000_1011, 0, 1'b1);
    check("t5a.err", {31'd0, cfg_err}, 1);
    stream("t5a", 16'b1011011, 7);
    idle("t5a", 2);
    load("t5b", 8'b0000_1011, 9, 1'b1);
    check("t5b.err", {31'd0, cfg_err}, 1);
    stream("t5b", 16'b1011011, 7);
    idle("t5b", 2);
    check("t5b.total", {24'd0, match_count}, 0);
    load("t5c", 8'b0000_1011, 4, 1'b1);
    check("t5c.err", {31'd0, cfg_err}, 0);
    stream("t5c", 16'b1011, 4);
    idle("t5c", 2);
    check("t5c.total", {24'd0, match_count}, 1);

    // 6: single-bit pattern, back-to-back pulses, 2-bit counter saturates
    load("t6", 8'b0000_0001, 1, 1'b1);
    stream("t6", 16'b11111, 5);
    step("t6", 1'b0, 1'b0);
    check("t6.pulse5", {31'd0, detect_out}, 1);
    check("t6.sat2", {30'd0, count_c2}, 3);
    check("t6.cnt8", {24'd0, match_count}, 5);
    #1 reset = 1'b1;
    #1;
    check("t6.async_detect", {31'd0, detect_out}, 0);
    check("t6.async_count",  {24'd0, match_count}, 0);
    check("t6.async_count2", {30'd0, count_c2}, 0);
    do_reset("t6r");

    // Default config is back after reset
    stream("t7", 16'b1011, 4);
    idle("t7", 2);
    check("t7.total", {24'd0, match_count}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
